fir_coeff_loader: RTL and testbench

- Transmit side of the FIR coefficient-load interface (load_coeff / coeff_in / start).
- Accepts a coefficient set from a host over a valid/ready stream and buffers all N words.
- Replays the set to the direct-form pipelined FIR as a burst of N consecutive load_coeff cycles, then drives start to run the filter.
- The filter's load index is a free-running IDXW-bit counter that only clears on rst. This block is the single owner of that index alignment.

---
 rtl/fir_coeff_loader.sv | 149 ++++++++++++++
 tb/tb_fir_coeff_loader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_loader.sv
// Buffers a host coefficient set and replays it as a load_coeff burst to the FIR.
// FIR_COEFF_RELOAD_PAD_EN: reloads pad the FIR index to wrap, else they are rejected.
module fir_coeff_loader #(
    parameter int N    = 100,
    parameter int CW   = 16,
    parameter int IDXW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] host_coeff,
    input  logic          host_valid,
    output logic          host_ready,
    input  logic          run_en,
    output logic          load_coeff,
    output logic [CW-1:0] coeff_out,
    output logic          start_out,
    output logic          loaded,
    output logic          busy,
    output logic          err_reload
);
    localparam int PW   = (N > 1) ? $clog2(N) : 1;
    localparam int PADN = (1 << IDXW) - N;

    typedef enum logic [1:0] {FILL, PAD, STREAM, RUN} state_t;

    state_t          state, state_d;
    logic [PW-1:0]   wr_ptr, wr_ptr_d;
    logic [PW-1:0]   rd_idx, rd_idx_d, rd_nxt;
    logic [IDXW-1:0] pad_cnt, pad_cnt_d;
    logic [CW-1:0]   mem [N];
    logic [CW-1:0]   coeff_d, first_word;
    logic            ready_d, load_d, start_d;
    logic            loaded_d, busy_d, err_d;
    logic            take, last_word;

    assign take      = host_valid & host_ready;
    assign last_word = take && (wr_ptr == PW'(N - 1));
    assign rd_nxt    = rd_idx + 1'b1;
    // A one-word set has not reached the buffer yet when it completes
    assign first_word = (N == 1) ? host_coeff : mem[0];

    always_ff @(posedge clk) begin
        if (take)
            mem[wr_ptr] <= host_coeff;
    end

    always_comb begin
        state_d   = state;
        wr_ptr_d  = wr_ptr;
        rd_idx_d  = rd_idx;
        pad_cnt_d = pad_cnt;
        ready_d   = host_ready;
        load_d    = 1'b0;
        coeff_d   = '0;
        start_d   = 1'b0;
        loaded_d  = loaded;
        busy_d    = busy;
        err_d     = err_reload;
        if (take)
            wr_ptr_d = last_word ? '0 : wr_ptr + 1'b1;
        unique case (state)
            FILL: begin
                ready_d = 1'b1;
                if (last_word) begin
                    state_d  = STREAM;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                    load_d   = 1'b1;
                    coeff_d  = first_word;
                    rd_idx_d = '0;
                end
            end
            RUN: begin
                ready_d = 1'b1;
                start_d = run_en;
                if (last_word) begin
`ifdef FIR_COEFF_RELOAD_PAD_EN
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    load_d  = 1'b1;
                    start_d = 1'b0;
                    if (PADN == 0) begin
                        state_d  = STREAM;
                        coeff_d  = first_word;
                        rd_idx_d = '0;
                    end else begin
                        state_d   = PAD;
                        pad_cnt_d = '0;
                    end
`else
                    err_d = 1'b1;
`endif
                end
            end
            PAD: begin
                load_d = 1'b1;
                if (pad_cnt == IDXW'(PADN - 1)) begin
                    state_d  = STREAM;
                    coeff_d  = mem[0];
                    rd_idx_d = '0;
                end else begin
                    pad_cnt_d = pad_cnt + 1'b1;
                end
            end
            STREAM: begin
                if (rd_idx == PW'(N - 1)) begin
                    state_d  = RUN;
                    ready_d  = 1'b1;
                    busy_d   = 1'b0;
                    loaded_d = 1'b1;
                    start_d  = run_en;
                end else begin
                    load_d   = 1'b1;
                    rd_idx_d = rd_nxt;
                    coeff_d  = mem[rd_nxt];
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            wr_ptr     <= '0;
            rd_idx     <= '0;
            pad_cnt    <= '0;
            host_ready <= 1'b0;
            load_coeff <= 1'b0;
            coeff_out  <= '0;
            start_out  <= 1'b0;
            loaded     <= 1'b0;
            busy       <= 1'b0;
            err_reload <= 1'b0;
        end else begin
            state      <= state_d;
            wr_ptr     <= wr_ptr_d;
            rd_idx     <= rd_idx_d;
            pad_cnt    <= pad_cnt_d;
            host_ready <= ready_d;
            load_coeff <= load_d;
            coeff_out  <= coeff_d;
            start_out  <= start_d;
            loaded     <= loaded_d;
            busy       <= busy_d;
            err_reload <= err_d;
        end
    end
endmodule

// File: tb/tb_fir_coeff_loader.sv
// Bench for fir_coeff_loader: table vectors, corner sequences and random sets
// checked against a set-level model of what the FIR should receive.
module tb_fir_coeff_loader;
    localparam int N     = 100;
    localparam int CW    = 16;
    localparam int IDXW  = 7;
    localparam int DEPTH = 1 << IDXW;
    localparam int PADN  = DEPTH - N;
`ifdef FIR_COEFF_RELOAD_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] host_coeff = '0;
    logic          host_valid = 1'b0;
    logic          run_en = 1'b0;
    logic          host_ready, load_coeff, start_out, loaded, busy, err_reload;
    logic [CW-1:0] coeff_out;

    fir_coeff_loader #(.N(N), .CW(CW), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst),
        .host_coeff(host_coeff), .host_valid(host_valid), .host_ready(host_ready),
        .run_en(run_en), .load_coeff(load_coeff), .coeff_out(coeff_out),
        .start_out(start_out), .loaded(loaded), .busy(busy), .err_reload(err_reload)
    );

    always #5 clk = ~clk;

    // FIR-side observer: the filter's own index/tap view plus rule violations
    logic [CW-1:0] got_q [$];
    logic [CW-1:0] fir_taps [DEPTH];
    int   fir_idx = 0;
    int   bursts = 0, start_bad = 0, overlap_bad = 0, ready_bad = 0;
    logic prev_run = 1'b0, prev_load = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            fir_idx   <= 0;
            prev_load <= 1'b0;
            prev_run  <= 1'b0;
            foreach (fir_taps[k]) fir_taps[k] <= '0;
        end else begin
            if (load_coeff) begin
                got_q.push_back(coeff_out);
                fir_taps[fir_idx] <= coeff_out;
                fir_idx <= (fir_idx + 1) % DEPTH;
                if (!prev_load) bursts <= bursts + 1;
            end
            if (load_coeff && start_out) overlap_bad <= overlap_bad + 1;
            if (loaded && !busy && !load_coeff) begin
                if (start_out !== prev_run) start_bad <= start_bad + 1;
            end else if (start_out !== 1'b0) begin
                start_bad <= start_bad + 1;
            end
            if ((busy && host_ready) || (loaded && !busy && !host_ready))
                ready_bad <= ready_bad + 1;
            prev_load <= load_coeff;
            prev_run  <= run_en;
        end
    end

    typedef struct {
        bit do_rst;
        int base;
        int mode;
        bit run;
        int exp_loads;
        bit exp_err;
    } vec_t;

    vec_t          vec [4];
    int            passed = 0, total = 0;
    logic [CW-1:0] vals [N];
    logic [CW-1:0] m_taps [N];
    logic [CW-1:0] exp_q [$];
    bit            m_loaded = 0, m_err = 0, rnd_run = 0;
    int            m_loads = 0;
    int            g0, b0, s0, o0, r0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_clear();
        m_loaded = 0;
        m_err    = 0;
        m_loads  = 0;
        foreach (m_taps[k]) m_taps[k] = '0;
    endtask

    // What the FIR should receive for the set now in vals[]
    task automatic model_set();
        exp_q.delete();
        if (!m_loaded || PAD_EN) begin
            if (m_loaded) repeat (PADN) exp_q.push_back('0);
            for (int k = 0; k < N; k++) begin
                exp_q.push_back(vals[k]);
                m_taps[k] = vals[k];
            end
            m_loads  += exp_q.size();
            m_loaded = 1;
        end else begin
            m_err = 1;
        end
    endtask

    task automatic snap();
        g0 = got_q.size();
        b0 = bursts;
        s0 = start_bad;
        o0 = overlap_bad;
        r0 = ready_bad;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        host_valid = 1'b0;
        @(posedge clk); #1;
        check("reset outputs",
              int'({host_ready, load_coeff, coeff_out, start_out, loaded, busy, err_reload}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready after reset", int'(host_ready), 1);
        model_clear();
    endtask

    // mode 0: valid held, 1: valid toggles, 2: random valid
    task automatic push_set(input int mode);
        int i = 0;
        int guard = 0;
        bit ph = 1'b1;
        bit acc;
        while (i < N && guard < 4000) begin
            host_coeff = vals[i];
            if (mode == 0) host_valid = 1'b1;
            else if (mode == 1) host_valid = ph;
            else host_valid = ($urandom_range(0, 3) != 0);
            ph = ~ph;
            if (rnd_run) run_en = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = host_valid && host_ready;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
        end
        host_valid = 1'b0;
        check("push complete", i, N);
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy && g < 1000) begin
            if (rnd_run) run_en = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            g++;
        end
        repeat (3) begin
            if (rnd_run) run_en = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    task automatic verify(input string tag);
        int n;
        int bad;
        n = got_q.size() - g0;
        bad = 0;
        check({tag, " loads"}, n, exp_q.size());
        for (int k = 0; k < n && k < exp_q.size(); k++)
            if (got_q[g0 + k] !== exp_q[k]) bad++;
        check({tag, " stream"}, bad, 0);
        check({tag, " bursts"}, bursts - b0, (exp_q.size() > 0) ? 1 : 0);
        check({tag, " err"}, int'(err_reload), int'(m_err));
        check({tag, " loaded"}, int'(loaded), int'(m_loaded));
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " fir idx"}, fir_idx, m_loads % DEPTH);
        bad = 0;
        for (int k = 0; k < N; k++)
            if (fir_taps[k] !== m_taps[k]) bad++;
        check({tag, " taps"}, bad, 0);
        check({tag, " start rule"}, start_bad - s0, 0);
        check({tag, " load/start overlap"}, overlap_bad - o0, 0);
        check({tag, " ready rule"}, ready_bad - r0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int bad;
        int g;
        vec[0] = '{1'b1, 1,   0, 1'b1, N, 1'b0};
        vec[1] = '{1'b1, 1,   1, 1'b1, N, 1'b0};
        vec[2] = '{1'b0, 201, 0, 1'b1, PAD_EN ? PADN + N : 0, !PAD_EN};
        vec[3] = '{1'b0, 301, 2, 1'b0, PAD_EN ? PADN + N : 0, !PAD_EN};

        for (int v = 0; v < 4; v++) begin
            if (vec[v].do_rst) do_reset();
            for (int k = 0; k < N; k++) vals[k] = CW'(vec[v].base + k);
            run_en = vec[v].run;
            snap();
            push_set(vec[v].mode);
            model_set();
            wait_idle();
            check($sformatf("vec%0d table loads", v), got_q.size() - g0, vec[v].exp_loads);
            verify($sformatf("vec%0d", v));
        end

        // run_en low for 10 cycles, then high: start_out follows one cycle later
        run_en = 1'b0;
        @(posedge clk); #1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (start_out !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        check("run_en low start", bad, 0);
        run_en = 1'b1;
        @(negedge clk);
        check("start same cycle", int'(start_out), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("start next cycle", int'(start_out), 1);
        @(posedge clk); #1;

        // reset in the middle of the stream, then a fresh set of sevens
        do_reset();
        for (int k = 0; k < N; k++) vals[k] = CW'(k + 1);
        run_en = 1'b1;
        g0 = got_q.size();
        push_set(0);
        g = 0;
        while (got_q.size() - g0 < 50 && g < 500) begin
            @(posedge clk); #1;
            g++;
        end
        check("mid-stream count", got_q.size() - g0, 50);
        rst = 1'b1;
        #1;
        check("async reset outputs",
              int'({host_ready, load_coeff, coeff_out, start_out, loaded, busy, err_reload}), 0);
        do_reset();
        for (int k = 0; k < N; k++) vals[k] = CW'(7);
        snap();
        push_set(1);
        model_set();
        wait_idle();
        verify("sevens");

        // random values, random valid gaps, random run_en, then a reload
        do_reset();
        rnd_run = 1'b1;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < N; k++) vals[k] = CW'($urandom_range(0, 65535));
            snap();
            push_set(2);
            model_set();
            wait_idle();
            verify($sformatf("rnd%0d", s));
        end
        rnd_run = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
